// File: rtl/led_pkg.sv
// Constants and decoder state encoding shared by the strand driver and decoder.
package led_pkg;

    localparam int unsigned COLOR_W        = 8;
    localparam int unsigned BITS_PER_PIXEL = 24;

    localparam int unsigned GREEN_LSB = 16;
    localparam int unsigned RED_LSB   = 8;
    localparam int unsigned BLUE_LSB  = 0;

    typedef logic [1:0] dec_state_t;

    localparam dec_state_t StSync = 2'd0;
    localparam dec_state_t StIdle = 2'd1;
    localparam dec_state_t StHigh = 2'd2;
    localparam dec_state_t StLow  = 2'd3;

endpackage

// File: rtl/led_strand_decoder_if.sv
// Decoded pixel/frame bus; the decoder drives it as master, consumers listen as slave.
interface led_strand_decoder_if
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 2
) ();

    localparam int unsigned IdxW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned CntW = $clog2(NUM_LEDS + 1);

    logic [COLOR_W-1:0] green_out;
    logic [COLOR_W-1:0] red_out;
    logic [COLOR_W-1:0] blue_out;
    logic               pixel_valid;
    logic [IdxW-1:0]    pixel_index;
    logic               frame_done;
    logic [CntW-1:0]    pixel_count;
    logic               error_out;
    logic               overflow_out;

    modport master (
        output green_out, red_out, blue_out, pixel_valid, pixel_index,
               frame_done, pixel_count, error_out, overflow_out
    );

    modport slave (
        input green_out, red_out, blue_out, pixel_valid, pixel_index,
              frame_done, pixel_count, error_out, overflow_out
    );

endinterface

// File: rtl/strand_sync_edge.sv
// Two-flop synchronizer for the strand pin plus a third register for rise/fall strobes.
module strand_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_strand,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_strand;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/led_strand_decoder.sv
// Decodes a WS2812-style NRZ strand into GRB pixels, with frame-end, error and overflow strobes.
module led_strand_decoder
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS             = 2,
    parameter int unsigned MIN_HIGH_CYCLES      = 20,
    parameter int unsigned BIT_THRESHOLD_CYCLES = 60,
    parameter int unsigned MAX_HIGH_CYCLES      = 110,
    parameter int unsigned RESET_CYCLES         = 5000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic strand_in,
    led_strand_decoder_if.master pix
);

    localparam int unsigned IdxW  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned CntW  = $clog2(NUM_LEDS + 1);
    localparam int unsigned HighW = $clog2(MAX_HIGH_CYCLES + 2);
    localparam int unsigned LowW  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned BitW  = $clog2(BITS_PER_PIXEL);

    localparam logic [HighW-1:0] HighMin = HighW'(MIN_HIGH_CYCLES);
    localparam logic [HighW-1:0] HighThr = HighW'(BIT_THRESHOLD_CYCLES);
    localparam logic [HighW-1:0] HighMax = HighW'(MAX_HIGH_CYCLES);
    localparam logic [HighW-1:0] HighSat = HighW'(MAX_HIGH_CYCLES + 1);
    localparam logic [LowW-1:0]  LowEnd  = LowW'(RESET_CYCLES);
    localparam logic [BitW-1:0]  BitLast = BitW'(BITS_PER_PIXEL - 1);
    localparam logic [CntW-1:0]  PixMax  = CntW'(NUM_LEDS);

    logic w_level;
    logic w_rise;
    logic w_fall;

    strand_sync_edge u_sync (
        .i_clk    (clk_in),
        .i_rst    (rst_in),
        .i_strand (strand_in),
        .o_level  (w_level),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    dec_state_t                r_state;
    logic [HighW-1:0]          r_high_cnt;
    logic [LowW-1:0]           r_low_cnt;
    logic [BITS_PER_PIXEL-1:0] r_shift;
    logic [BitW-1:0]           r_bit_cnt;
    logic [CntW-1:0]           r_pix_cnt;
    logic                      r_ovf_seen;
    logic                      r_pix_pend;

    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_blue;
    logic               r_pixel_valid;
    logic [IdxW-1:0]    r_pixel_index;
    logic               r_frame_done;
    logic [CntW-1:0]    r_pixel_count;
    logic               r_error;
    logic               r_overflow;

    logic [HighW-1:0] w_high_inc;
    logic [LowW-1:0]  w_low_inc;
    logic             w_bit;
    logic             w_pulse_err;

    always_comb begin
        w_high_inc  = (r_high_cnt == HighSat) ? r_high_cnt : r_high_cnt + HighW'(1);
        w_low_inc   = (r_low_cnt == LowEnd) ? r_low_cnt : r_low_cnt + LowW'(1);
        w_bit       = (r_high_cnt >= HighThr);
        w_pulse_err = (r_state == StHigh) &&
                      ((w_fall && (r_high_cnt < HighMin)) ||
                       (w_level && (w_high_inc > HighMax)));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= StSync;
            r_high_cnt    <= '0;
            r_low_cnt     <= '0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_pix_cnt     <= '0;
            r_ovf_seen    <= 1'b0;
            r_pix_pend    <= 1'b0;
            r_green       <= '0;
            r_red         <= '0;
            r_blue        <= '0;
            r_pixel_valid <= 1'b0;
            r_pixel_index <= '0;
            r_frame_done  <= 1'b0;
            r_pixel_count <= '0;
            r_error       <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_error       <= 1'b0;
            r_overflow    <= 1'b0;
            r_pix_pend    <= 1'b0;

            // Emit the pixel one cycle after its 24th bit was shifted in.
            if (r_pix_pend) begin
                if (r_pix_cnt < PixMax) begin
                    r_pixel_valid <= 1'b1;
                    r_green       <= r_shift[GREEN_LSB +: COLOR_W];
                    r_red         <= r_shift[RED_LSB +: COLOR_W];
                    r_blue        <= r_shift[BLUE_LSB +: COLOR_W];
                    r_pixel_index <= r_pix_cnt[IdxW-1:0];
                    r_pix_cnt     <= r_pix_cnt + CntW'(1);
                end else if (!r_ovf_seen) begin
                    r_overflow <= 1'b1;
                    r_ovf_seen <= 1'b1;
                end
            end

            case (r_state)
                StSync: begin
                    if (w_level) begin
                        r_low_cnt <= '0;
                    end else if (w_low_inc == LowEnd) begin
                        r_low_cnt <= '0;
                        r_state   <= StIdle;
                    end else begin
                        r_low_cnt <= w_low_inc;
                    end
                end
                StIdle: begin
                    if (w_rise) begin
                        r_high_cnt <= HighW'(1);
                        r_state    <= StHigh;
                    end
                end
                StHigh: begin
                    if (w_fall) begin
                        r_shift   <= {r_shift[BITS_PER_PIXEL-2:0], w_bit};
                        r_low_cnt <= LowW'(1);
                        r_state   <= StLow;
                        if (r_bit_cnt == BitLast) begin
                            r_bit_cnt  <= '0;
                            r_pix_pend <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BitW'(1);
                        end
                    end else if (w_level) begin
                        r_high_cnt <= w_high_inc;
                    end
                end
                default: begin
                    if (w_rise) begin
                        r_high_cnt <= HighW'(1);
                        r_state    <= StHigh;
                    end else if (w_low_inc == LowEnd) begin
                        r_frame_done  <= 1'b1;
                        r_pixel_count <= r_pix_cnt;
                        r_error       <= (r_bit_cnt != '0);
                        r_pix_cnt     <= '0;
                        r_bit_cnt     <= '0;
                        r_shift       <= '0;
                        r_ovf_seen    <= 1'b0;
                        r_low_cnt     <= '0;
                        r_state       <= StIdle;
                    end else begin
                        r_low_cnt <= w_low_inc;
                    end
                end
            endcase

            // A bad pulse abandons the whole frame and resynchronises; it outranks any pixel.
            if (w_pulse_err) begin
                r_error       <= 1'b1;
                r_pixel_valid <= 1'b0;
                r_pix_pend    <= 1'b0;
                r_state       <= StSync;
                r_high_cnt    <= '0;
                r_low_cnt     <= '0;
                r_shift       <= '0;
                r_bit_cnt     <= '0;
                r_pix_cnt     <= '0;
                r_ovf_seen    <= 1'b0;
            end
        end
    end

    assign pix.green_out    = r_green;
    assign pix.red_out      = r_red;
    assign pix.blue_out     = r_blue;
    assign pix.pixel_valid  = r_pixel_valid;
    assign pix.pixel_index  = r_pixel_index;
    assign pix.frame_done   = r_frame_done;
    assign pix.pixel_count  = r_pixel_count;
    assign pix.error_out    = r_error;
    assign pix.overflow_out = r_overflow;

endmodule
